hazard_detect_unit: RTL
=======================

# hazard_detect_unit

Pipeline hazard and stall controller for the five-stage MIPS datapath, sitting in ID beside the register file and upstream of the EX/ID forwarding logic. Detects load-use and branch-operand hazards the forwarding paths cannot cover and freezes PC and IF/ID. Inserts a bubble into ID/EX and flushes IF/ID on taken branches and jumps. Keeps saturating stall and flush cycle counters for performance measurement.

## Interface
- CNT_W, 16, width of each performance counter
- clk  input  1  pipeline clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- ID_rs  input  5  rs field of the instruction in ID
- ID_rt  input  5  rt field of the instruction in ID
- ID_UseRt  input  1  the ID instruction reads rt (R-type, beq/bne, sw)
- Branch  input  1  ID instruction is beq/bne (compared in ID)
- BranchTaken  input  1  ID branch comparison result is "taken"
- Jump  input  1  ID instruction is j/jal/jr
- EX_RegWrite  input  1  EX instruction writes a register
- EX_MemRead  input  1  EX instruction is a load
- EX_Reg_Write  input  5  EX destination register
- MEM_MemRead  input  1  MEM instruction is a load
- MEM_Reg_Write  input  5  MEM destination register
- PCWrite  output  1  1 = PC may update
- IF_ID_Write  output  1  1 = IF/ID may load
- ID_EX_Flush  output  1  1 = load a bubble (all control zero) into ID/EX
- IF_ID_Flush  output  1  1 = load a nop into IF/ID
- stall_cycles  output  CNT_W  saturating count of stall cycles
- flush_cycles  output  CNT_W  saturating count of IF/ID flush cycles

## Operation
- Match terms (register 0 never matches): mA = ID_rs equals reg; mB = ID_UseRt and ID_rt equals reg; m = mA or mB.
- Required stall count N, evaluated in RUN:
  - N=2: Branch and EX_MemRead and m(EX_Reg_Write).
  - N=1: EX_MemRead and m(EX_Reg_Write) (load-use, non-branch).
  - N=1: Branch and EX_RegWrite and not EX_MemRead and m(EX_Reg_Write).
  - N=1: Branch and MEM_MemRead and m(MEM_Reg_Write).
  - else N=0. Highest N wins when several hold.
- FSM states: RUN, STALL_HOLD.
  - RUN, N=0: no stall. If Jump, or Branch and BranchTaken: IF_ID_Flush=1.
  - RUN, N=1: stall this cycle; stay RUN, re-evaluate next cycle.
  - RUN, N=2: stall this cycle; next state STALL_HOLD.
  - STALL_HOLD: stall unconditionally for one cycle regardless of inputs; next state RUN.
- Stall cycle: PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1, IF_ID_Flush=0.
- Non-stall cycle: PCWrite=1, IF_ID_Write=1, ID_EX_Flush=0.
- While stalling, BranchTaken and Jump are ignored; a branch is resolved only on its non-stall cycle.
- stall_cycles increments on every stall cycle and flush_cycles on every IF_ID_Flush cycle. Each saturates at all-ones and never wraps.

## Timing
- Stall and flush outputs are combinational from the current state and inputs, valid in the same cycle as the hazard. State and counters update on the rising clk edge.
- Load-use hazard: exactly 1 bubble. Branch on an ALU result: 1 bubble, then the EX-to-ID forward path supplies the operand. Branch on a load in EX: 2 bubbles. Branch on a load in MEM: 1 bubble.
- Counters reflect a cycle's event from the following edge.
- rst high, at any time including mid STALL_HOLD: state becomes RUN, counters clear to 0, and outputs are forced to PCWrite=1, IF_ID_Write=1, ID_EX_Flush=0, IF_ID_Flush=0 while rst remains high.
- First evaluation happens on the first cycle after rst deasserts.

## Structure
- The shared pipeline package holds the state encoding (RUN=1'b0, STALL_HOLD=1'b1) and the ZERO_REG constant 5'd0.
- One sub-module, hazard_match: combinational match and N computation. The parent holds the FSM, output muxing and counters.

## Test plan
- Load-use: lw $2 in EX (EX_MemRead=1, EX_Reg_Write=2), add in ID with rs=2 -> one cycle with PCWrite=0 and ID_EX_Flush=1, then normal; stall_cycles=1.
- Branch after load: beq rs=3 in ID, lw $3 in EX -> two consecutive stall cycles, the second (STALL_HOLD) persisting even if inputs go to zero; stall_cycles=2.
- Branch after ALU: beq rt=4 (ID_UseRt=1), EX_RegWrite=1, EX_Reg_Write=4 -> one stall. Then BranchTaken=1 with no hazard -> IF_ID_Flush=1 for one cycle; flush_cycles=1.
- Register 0: lw $0 in EX, ID rs=0 -> no stall; Jump=1 -> IF_ID_Flush=1 only.
- Reset mid STALL_HOLD: assert rst asynchronously -> outputs go inactive immediately, counters read 0, state RUN after release.
- Saturation: CNT_W=4 with a continuous load-use hazard for 20 cycles -> stall_cycles holds at 15.

Source files
------------

// File: rtl/hazard_detect_unit_pkg.sv
// Shared pipeline definitions for the ID-stage hazard/stall controller:
// FSM state encoding, register-number constants and the operand match helper.
package hazard_detect_unit_pkg;

    // Width of a MIPS register specifier
    localparam int REG_W = 5;

    // $zero is hard-wired; writes to it never create a dependency
    localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

    // Stall-controller FSM states
    typedef enum logic {
        RUN        = 1'b0,
        STALL_HOLD = 1'b1
    } hz_state_e;

    // Number of bubbles a detected hazard requires
    typedef enum logic [1:0] {
        NEED_NONE = 2'd0,
        NEED_ONE  = 2'd1,
        NEED_TWO  = 2'd2
    } hz_need_e;

    // True when the ID instruction reads register wr_reg.
    // rs is always a source; rt only counts when the instruction uses it.
    function automatic logic reg_match(
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rt,
        input logic             use_rt,
        input logic [REG_W-1:0] wr_reg
    );
        logic m_a;
        logic m_b;
        m_a = (wr_reg != ZERO_REG) && (rs == wr_reg);
        m_b = (wr_reg != ZERO_REG) && use_rt && (rt == wr_reg);
        return m_a || m_b;
    endfunction

endpackage

// File: rtl/hazard_detect_unit_match.sv
// Combinational hazard classifier: compares the ID source operands against
// the EX and MEM destinations and reports how many bubbles are needed.
import hazard_detect_unit_pkg::*;

module hazard_match (
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic       ID_UseRt,
    input  logic       Branch,
    input  logic       EX_RegWrite,
    input  logic       EX_MemRead,
    input  logic [4:0] EX_Reg_Write,
    input  logic       MEM_MemRead,
    input  logic [4:0] MEM_Reg_Write,
    output hz_need_e   need_o
);

    logic m_ex_s;
    logic m_mem_s;
    logic branch_load_ex_s;
    logic load_use_s;
    logic branch_alu_ex_s;
    logic branch_load_mem_s;

    // Operand dependency terms against the EX and MEM destinations
    always_comb begin
        m_ex_s  = reg_match(ID_rs, ID_rt, ID_UseRt, EX_Reg_Write);
        m_mem_s = reg_match(ID_rs, ID_rt, ID_UseRt, MEM_Reg_Write);
    end

    // Individual hazard classes; a branch compares in ID so it needs its
    // operands one stage earlier than an ALU consumer would
    always_comb begin
        branch_load_ex_s  = Branch && EX_MemRead && m_ex_s;
        load_use_s        = EX_MemRead && m_ex_s;
        branch_alu_ex_s   = Branch && EX_RegWrite && !EX_MemRead && m_ex_s;
        branch_load_mem_s = Branch && MEM_MemRead && m_mem_s;
    end

    // Largest requirement wins when several hazards coexist
    always_comb begin
        need_o = NEED_NONE;
        if (branch_load_ex_s) begin
            need_o = NEED_TWO;
        end else if (load_use_s || branch_alu_ex_s || branch_load_mem_s) begin
            need_o = NEED_ONE;
        end else begin
            need_o = NEED_NONE;
        end
    end

endmodule

// File: rtl/hazard_detect_unit.sv
// ID-stage hazard and stall controller. Freezes PC and IF/ID and bubbles
// ID/EX on hazards forwarding cannot cover, flushes IF/ID on taken
// branches and jumps, and counts stall/flush cycles (saturating).
import hazard_detect_unit_pkg::*;

module hazard_detect_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_UseRt,
    input  logic             Branch,
    input  logic             BranchTaken,
    input  logic             Jump,
    input  logic             EX_RegWrite,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_Reg_Write,
    input  logic             MEM_MemRead,
    input  logic [4:0]       MEM_Reg_Write,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             ID_EX_Flush,
    output logic             IF_ID_Flush,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    hz_state_e        state_q;
    hz_state_e        state_d;
    hz_need_e         need_s;
    logic             stall_s;
    logic             flush_s;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d;

    hazard_match u_match (
        .ID_rs         (ID_rs),
        .ID_rt         (ID_rt),
        .ID_UseRt      (ID_UseRt),
        .Branch        (Branch),
        .EX_RegWrite   (EX_RegWrite),
        .EX_MemRead    (EX_MemRead),
        .EX_Reg_Write  (EX_Reg_Write),
        .MEM_MemRead   (MEM_MemRead),
        .MEM_Reg_Write (MEM_Reg_Write),
        .need_o        (need_s)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a two-bubble hazard parks in STALL_HOLD for one cycle
    always_comb begin
        state_d = RUN;
        case (state_q)
            RUN: begin
                if (need_s == NEED_TWO) begin
                    state_d = STALL_HOLD;
                end else begin
                    state_d = RUN;
                end
            end
            STALL_HOLD: state_d = RUN;
            default:    state_d = RUN;
        endcase
    end

    // FSM outputs: stall/flush decision; branch and jump only resolve on a
    // non-stall cycle, and reset forces the pipeline to free-run
    always_comb begin
        stall_s = 1'b0;
        flush_s = 1'b0;
        case (state_q)
            RUN: begin
                if (need_s != NEED_NONE) begin
                    stall_s = 1'b1;
                    flush_s = 1'b0;
                end else begin
                    stall_s = 1'b0;
                    flush_s = Jump || (Branch && BranchTaken);
                end
            end
            STALL_HOLD: begin
                stall_s = 1'b1;
                flush_s = 1'b0;
            end
            default: begin
                stall_s = 1'b0;
                flush_s = 1'b0;
            end
        endcase
        if (rst) begin
            stall_s = 1'b0;
            flush_s = 1'b0;
        end else begin
            stall_s = stall_s;
            flush_s = flush_s;
        end
    end

    // Pipeline control lines derived from the stall/flush decision
    always_comb begin
        PCWrite     = !stall_s;
        IF_ID_Write = !stall_s;
        ID_EX_Flush = stall_s;
        IF_ID_Flush = flush_s;
    end

    // Saturating next values for the performance counters
    always_comb begin
        if (stall_s && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (flush_s && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Performance counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= CNT_ZERO;
            flush_cnt_q <= CNT_ZERO;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_cycles = flush_cnt_q;

endmodule
